// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared prefetch constants and credit check
package fifo_pkg;

    localparam int PREFETCH_DEPTH = 2;
    localparam int LEVEL_W        = 2;

    // True when a new read can be issued without overrunning the buffer,
    // counting the word already in flight and the slot freed by a pop.
    function automatic logic credit_ok(
        input logic [LEVEL_W-1:0] count,
        input logic               inflight,
        input logic               pop
    );
        logic [LEVEL_W:0] need;
        need = {1'b0, count} + {{LEVEL_W{1'b0}}, inflight} - {{LEVEL_W{1'b0}}, pop};
        return need < (LEVEL_W+1)'(PREFETCH_DEPTH);
    endfunction

endpackage

// File: rtl/rd_prefetch_buf.sv
// rtl/rd_prefetch_buf.sv - two-entry circular prefetch register file
module rd_prefetch_buf
    import fifo_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head_data,
    output logic [LEVEL_W-1:0] count
);

    logic [WIDTH-1:0]   entry [PREFETCH_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [LEVEL_W-1:0] count_q;

    // Push writes the tail, pop advances the head; both may happen together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PREFETCH_DEPTH; i++) begin
                entry[i] <= '0;
            end
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count_q <= '0;
        end else begin
            if (push) begin
                entry[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count_q <= count_q + LEVEL_W'(push) - LEVEL_W'(pop);
        end
    end

    assign head_data = entry[rd_ptr];
    assign count     = count_q;

endmodule

// File: rtl/fifo_rd_prefetch.sv
// rtl/fifo_rd_prefetch.sv - FIFO read-side prefetch stage with FWFT stream output
module fifo_rd_prefetch
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int BUF_DEPTH = 2
) (
    input  logic               rd_clk,
    input  logic               rd_rst,
    input  logic               fifo_empty,
    output logic               fifo_rd_en,
    input  logic [WIDTH-1:0]   fifo_rd_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [WIDTH-1:0]   m_data,
    output logic [LEVEL_W-1:0] level
);

    if (BUF_DEPTH != PREFETCH_DEPTH) begin : g_depth_check
        $error("fifo_rd_prefetch supports BUF_DEPTH=2 only");
    end

    logic               inflight;
    logic               pop;
    logic               issue;
    logic [LEVEL_W-1:0] count;

    // Credit-based read issue: never request while empty or while in reset.
    always_comb begin
        pop        = 1'b0;
        fifo_rd_en = 1'b0;
        issue      = 1'b0;
        m_valid    = (count != '0);
        pop        = m_valid & m_ready;
        fifo_rd_en = ~rd_rst & ~fifo_empty & credit_ok(count, inflight, pop);
        issue      = fifo_rd_en & ~fifo_empty;
    end

    // The memory returns data one cycle after an accepted read.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
        end
    end

    rd_prefetch_buf #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (rd_clk),
        .rst       (rd_rst),
        .push      (inflight),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .head_data (m_data),
        .count     (count)
    );

    assign level = count;

endmodule
